dbf_weight_gen: RTL
===================

# dbf_weight_gen

Generates the complex beamforming weight for one array element. It converts a steering phase into the `ph_real`/`ph_image` pair and the `phase_data_valid` strobe consumed by the DBF cells. It sits between the beam-steering controller, which supplies one phase per element, and the per-element DBF multipliers. The conversion uses an iterative 16-step CORDIC in rotation mode with gain pre-compensation and a channel tag passed through.

## Interface
- `ITER`, 16: CORDIC iteration count; fixed at 16 for this build.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `phase_in` in 16: steering phase, signed fix16_13; ±pi = ±25736.
- `phase_in_ch` in 4: element/channel tag; returned with the result.
- `phase_in_valid` in 1: request strobe; accepted only when `phase_in_ready`=1.
- `phase_in_ready` out 1: block idle and able to accept.
- `ph_real` out 16: cos(phase), signed fix16_14; 1.0 = 16384.
- `ph_image` out 16: sin(phase), signed fix16_14.
- `ph_ch` out 4: tag of the current result.
- `phase_data_valid` out 1: one-cycle pulse; result valid.
- `drop_cnt` out 8: saturating count of requests ignored while busy.

## Operation
- States:
  - IDLE: ready=1. `phase_in_valid` → latch phase and tag → PRE.
  - PRE, 1 cycle: clamp, quadrant fold, load x/y/z.
  - ITER, `ITER` cycles: one micro-rotation per cycle, i = 0..15.
  - POST, 1 cycle: round, apply quadrant sign, saturate, register outputs → IDLE.
- Clamp: `phase_in` > 25736 → 25736; < -25736 → -25736.
- Fold:
  - phase > 12868 (pi/2): z = phase - 25736, negate flag = 1.
  - phase < -12868: z = phase + 25736, negate flag = 1.
  - Otherwise: z = phase, flag = 0.
- Internal widths:
  - x, y: 20-bit signed, 18 fractional bits.
  - z: 20-bit signed, 17 fractional bits (folded phase << 4).
  - x0 = 159188 (0.607253·2^18), y0 = 0.
- Iteration: d = (z ≥ 0) ? +1 : -1.
  - x ← x - d·(y >>> i)
  - y ← y + d·(x >>> i)
  - z ← z - d·atan_tab[i]
  - atan_tab[i] = round(atan(2^-i)·2^17), a 16-entry constant ROM.
- Output:
  - Round x and y by adding 8, then arithmetic shift right by 4.
  - Negate both if the flag is set.
  - Saturate to [-32768, 32767].
- `drop_cnt`: +1 when `phase_in_valid`=1 and ready=0; holds at 255. Dropped requests are not queued.
- `ph_real`, `ph_image` and `ph_ch` hold their last value until the next POST.
- Accuracy: |error| ≤ 4 LSB vs ideal round(16384·cos/sin) over the full input range.

## Timing
- Accept edge is cycle 0; `phase_data_valid` pulses in cycle 18, registered from POST.
- `phase_in_ready` falls the cycle after accept. It rises in the same cycle as `phase_data_valid`.
- A new request presented in the valid cycle is accepted. Throughput is 1 weight per 18 cycles.
- Reset values: ready=1, `phase_data_valid`=0, `ph_real`=0, `ph_image`=0, `ph_ch`=0, `drop_cnt`=0, state=IDLE.
- Reset mid-operation aborts the conversion. No valid pulse follows for the aborted request.
- `phase_in_valid` in the ready=1 cycle takes priority over counting; it never increments `drop_cnt`.

## Test plan
- Phase 0, ch 3 → cycle 18: real 16384±4, image 0±4, `ph_ch`=3, single-cycle valid.
- Quadrant angles:
  - 12868 → (0±4, 16384±4).
  - -12868 → (0±4, -16384±4).
  - 6434 → (11585±4, 11585±4).
  - -25736 → (-16384±4, 0±4).
- Phases 30000 and -30000 → same outputs as ±25736 (clamp).
- Request at cycle 0, 5 extra valids at cycles 3–7 → one result, `drop_cnt`=5. Request in the result cycle → accepted, second valid 18 cycles later.
- Assert `rst` at cycle 9 of a conversion → outputs 0, ready=1 next cycle, no valid pulse. Post-reset request at phase 0 → correct result.
- Sweep -25736..25736 in steps of 97 → every output within ±4 LSB of a double-precision model. 300 busy drops → `drop_cnt` saturates at 255.

Source files
------------

// File: rtl/dbf_weight_gen.sv
// Per-element beamforming weight generator: steering phase -> (cos, sin) via a
// 16-step rotation-mode CORDIC with quadrant folding and a pass-through channel tag.
module dbf_weight_gen #(
    parameter int unsigned ITER = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] phase_in,
    input  logic [3:0]  phase_in_ch,
    input  logic        phase_in_valid,
    output logic        phase_in_ready,
    output logic [15:0] ph_real,
    output logic [15:0] ph_image,
    output logic [3:0]  ph_ch,
    output logic        phase_data_valid,
    output logic [7:0]  drop_cnt
);
    localparam int unsigned PW = 16;
    localparam int unsigned CW = 20;
    localparam int unsigned TW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned IW = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic signed [PW-1:0] PI_P   = PW'(25736);
    localparam logic signed [PW-1:0] PI_H   = PW'(12868);
    localparam logic signed [CW-1:0] X0     = CW'(159188);
    localparam logic signed [CW:0]   RND    = (CW+1)'(8);
    localparam logic signed [CW:0]   SAT_HI = (CW+1)'(32767);
    localparam logic signed [CW:0]   SAT_LO = -(CW+1)'(32768);

    // round(atan(2^-i) * 2^17)
    localparam logic signed [CW-1:0] ATAN [16] = '{
        20'sd102944, 20'sd60771, 20'sd32110, 20'sd16299,
        20'sd8181,   20'sd4095,  20'sd2048,  20'sd1024,
        20'sd512,    20'sd256,   20'sd128,   20'sd64,
        20'sd32,     20'sd16,    20'sd8,     20'sd4
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_ITER = 2'd2,
        S_POST = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic signed [PW-1:0]  phase_q, phase_d;
    logic [TW-1:0]         ch_q, ch_d;
    logic signed [CW-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
    logic                  neg_q, neg_d;
    logic [IW-1:0]         it_q, it_d;
    logic                  ready_q, ready_d;
    logic                  valid_q, valid_d;
    logic [PW-1:0]         re_q, re_d, im_q, im_d;
    logic [TW-1:0]         och_q, och_d;
    logic [DW-1:0]         drop_q, drop_d;

    logic signed [PW-1:0]  pc, fz;
    logic signed [CW-1:0]  dx, dy;
    logic signed [CW:0]    xs, ys;

    function automatic logic [PW-1:0] sat16(input logic signed [CW:0] v);
        if (v > SAT_HI)      return 16'h7FFF;
        else if (v < SAT_LO) return 16'h8000;
        else                 return v[PW-1:0];
    endfunction

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        ch_d    = ch_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        neg_d   = neg_q;
        it_d    = it_q;
        ready_d = ready_q;
        valid_d = 1'b0;
        re_d    = re_q;
        im_d    = im_q;
        och_d   = och_q;
        drop_d  = drop_q;
        pc      = '0;
        fz      = '0;
        dx      = '0;
        dy      = '0;
        xs      = '0;
        ys      = '0;

        if (phase_in_valid && !ready_q && (drop_q != {DW{1'b1}})) begin
            drop_d = drop_q + DW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (phase_in_valid) begin
                    phase_d = $signed(phase_in);
                    ch_d    = phase_in_ch;
                    ready_d = 1'b0;
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                if (phase_q > PI_P)       pc = PI_P;
                else if (phase_q < -PI_P) pc = -PI_P;
                else                      pc = phase_q;
                // Fold outer half-planes onto [-pi/2, pi/2]; result sign is restored in POST
                if (pc > PI_H) begin
                    fz    = pc - PI_P;
                    neg_d = 1'b1;
                end else if (pc < -PI_H) begin
                    fz    = pc + PI_P;
                    neg_d = 1'b1;
                end else begin
                    fz    = pc;
                    neg_d = 1'b0;
                end
                x_d     = X0;
                y_d     = '0;
                z_d     = {fz, 4'b0000};
                it_d    = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                dx = x_q >>> it_q;
                dy = y_q >>> it_q;
                if (!z_q[CW-1]) begin
                    x_d = x_q - dy;
                    y_d = y_q + dx;
                    z_d = z_q - ATAN[it_q];
                end else begin
                    x_d = x_q + dy;
                    y_d = y_q - dx;
                    z_d = z_q + ATAN[it_q];
                end
                it_d = it_q + IW'(1);
                if (it_q == IW'(ITER - 1)) begin
                    state_d = S_POST;
                end
            end
            S_POST: begin
                xs = ($signed({x_q[CW-1], x_q}) + RND) >>> 4;
                ys = ($signed({y_q[CW-1], y_q}) + RND) >>> 4;
                if (neg_q) begin
                    xs = -xs;
                    ys = -ys;
                end
                re_d    = sat16(xs);
                im_d    = sat16(ys);
                och_d   = ch_q;
                valid_d = 1'b1;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            ch_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            neg_q   <= 1'b0;
            it_q    <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
            och_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ch_q    <= ch_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            neg_q   <= neg_d;
            it_q    <= it_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            re_q    <= re_d;
            im_q    <= im_d;
            och_q   <= och_d;
            drop_q  <= drop_d;
        end
    end

    assign phase_in_ready   = ready_q;
    assign phase_data_valid = valid_q;
    assign ph_real          = re_q;
    assign ph_image         = im_q;
    assign ph_ch            = och_q;
    assign drop_cnt         = drop_q;

endmodule
